// File: rtl/edge_line_sequencer_if.sv
// -----------------------------------------------------------------------------
// edge_line_sequencer_if
// Groups the pixel stream, detector hand-off and tagged result signals of the
// edge line sequencer.
//   slave  : the sequencer side (receives pixels and edge_in, drives the rest)
//   master : the environment side (pixel source, detector, frame writer)
// Signals:
//   enable, frame_start, pix_valid, pix_data : pixel source -> sequencer
//   ed_prev, ed_cur, ed_next, ed_rst         : sequencer -> detector
//   edge_in                                  : detector -> sequencer
//   out_valid, out_data, out_x, out_y        : tagged result -> frame writer
//   busy, frame_done, overrun                : status
// -----------------------------------------------------------------------------
interface edge_line_sequencer_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           enable;
  logic           frame_start;
  logic           pix_valid;
  logic [7:0]     pix_data;
  logic [7:0]     ed_prev;
  logic [7:0]     ed_cur;
  logic [7:0]     ed_next;
  logic           ed_rst;
  logic [7:0]     edge_in;
  logic           out_valid;
  logic [7:0]     out_data;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  modport master (
    output enable, frame_start, pix_valid, pix_data, edge_in,
    input  ed_prev, ed_cur, ed_next, ed_rst,
    input  out_valid, out_data, out_x, out_y, busy, frame_done, overrun
  );

  modport slave (
    input  enable, frame_start, pix_valid, pix_data, edge_in,
    output ed_prev, ed_cur, ed_next, ed_rst,
    output out_valid, out_data, out_x, out_y, busy, frame_done, overrun
  );
endinterface

// File: rtl/edge_line_sequencer.sv
// -----------------------------------------------------------------------------
// edge_line_sequencer
// Feeds a 3-tap vertical edge detector from a raster pixel stream. Two line
// buffers hold the previous two rows so every accepted pixel of row y issues
// the column triple centred on row y-1. The top row replicates upwards, the
// last row is flushed self-timed with downward replication, and every result
// coming back from the detector is tagged with its x/y.
// Ports:
//   VGA_CLK : pixel clock, all logic on the rising edge
//   RST_N   : synchronous active-low reset
//   bus     : edge_line_sequencer_if.slave (pixel in, detector, results, status)
// -----------------------------------------------------------------------------
module edge_line_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int EDGE_LAT = 3
) (
  input  logic                 VGA_CLK,
  input  logic                 RST_N,
  edge_line_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int             DW         = $clog2(EDGE_LAT + 2);
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_ONE      = Y_W'(1);
  // Last result leaves the output register EDGE_LAT+1 cycles into DRAIN.
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(EDGE_LAT + 1);

  state_t         state_r;
  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;
  logic [DW-1:0]  drain_cnt_r;

  logic [7:0]     lb_a_r [H_ACTIVE];
  logic [7:0]     lb_b_r [H_ACTIVE];

  logic [7:0]     ed_prev_r, ed_cur_r, ed_next_r;
  logic           ed_rst_r;
  logic           issue_r;
  logic [X_W-1:0] issue_x_r;
  logic [Y_W-1:0] issue_y_r;
  logic [EDGE_LAT-1:0] pipe_v_r;
  logic [X_W-1:0] pipe_x_r [EDGE_LAT];
  logic [Y_W-1:0] pipe_y_r [EDGE_LAT];

  logic           out_valid_r;
  logic [7:0]     out_data_r;
  logic [X_W-1:0] out_x_r;
  logic [Y_W-1:0] out_y_r;
  logic           busy_r, frame_done_r, overrun_r;

  logic           start_s, accept_s, flush_s, issue_s, drop_s, x_wrap_s;
  state_t         eff_state_s;
  logic [X_W-1:0] eff_x_s;
  logic [Y_W-1:0] eff_y_s;
  logic [7:0]     lb_a_rd_s, lb_b_rd_s;

  // Per-cycle decode; a start or abort makes this cycle behave as FILL at (0,0)
  always_comb begin
    start_s     = 1'b0;
    eff_state_s = state_r;
    eff_x_s     = x_r;
    eff_y_s     = y_r;
    if (bus.frame_start && ((state_r != IDLE) || bus.enable)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if (start_s) begin
      eff_state_s = FILL;
      eff_x_s     = {X_W{1'b0}};
      eff_y_s     = {Y_W{1'b0}};
    end else begin
      eff_state_s = state_r;
      eff_x_s     = x_r;
      eff_y_s     = y_r;
    end
    accept_s  = bus.pix_valid && ((eff_state_s == FILL) || (eff_state_s == RUN));
    flush_s   = (eff_state_s == FLUSH);
    issue_s   = (accept_s && (eff_state_s == RUN)) || flush_s;
    drop_s    = bus.pix_valid && flush_s;
    x_wrap_s  = (eff_x_s == X_LAST);
    lb_a_rd_s = lb_a_r[eff_x_s];
    lb_b_rd_s = lb_b_r[eff_x_s];
  end

  // Line buffers: read-then-shift column x on every accepted pixel (no reset)
  always_ff @(posedge VGA_CLK) begin
    if (accept_s) begin
      lb_b_r[eff_x_s] <= lb_a_rd_s;
      lb_a_r[eff_x_s] <= bus.pix_data;
    end
  end

  // Sequencer FSM, detector issue, latency pipeline and tagged outputs
  always_ff @(posedge VGA_CLK) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      x_r          <= {X_W{1'b0}};
      y_r          <= {Y_W{1'b0}};
      drain_cnt_r  <= {DW{1'b0}};
      ed_prev_r    <= 8'd0;
      ed_cur_r     <= 8'd0;
      ed_next_r    <= 8'd0;
      ed_rst_r     <= 1'b1;
      issue_r      <= 1'b0;
      issue_x_r    <= {X_W{1'b0}};
      issue_y_r    <= {Y_W{1'b0}};
      pipe_v_r     <= {EDGE_LAT{1'b0}};
      for (int i = 0; i < EDGE_LAT; i++) begin
        pipe_x_r[i] <= {X_W{1'b0}};
        pipe_y_r[i] <= {Y_W{1'b0}};
      end
      out_valid_r  <= 1'b0;
      out_data_r   <= 8'd0;
      out_x_r      <= {X_W{1'b0}};
      out_y_r      <= {Y_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      ed_rst_r     <= start_s;
      state_r      <= eff_state_s;
      x_r          <= eff_x_s;
      y_r          <= eff_y_s;
      busy_r       <= (eff_state_s != IDLE);
      frame_done_r <= 1'b0;

      // An abort is itself an error; a clean start clears the sticky flag.
      if (start_s) begin
        overrun_r <= (state_r != IDLE);
      end else if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (eff_state_s)
        IDLE: begin
          state_r <= IDLE;
        end
        FILL: begin
          if (accept_s) begin
            if (x_wrap_s) begin
              x_r     <= {X_W{1'b0}};
              y_r     <= Y_ONE;
              state_r <= RUN;
            end else begin
              x_r <= eff_x_s + X_W'(1);
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            if (x_wrap_s) begin
              x_r <= {X_W{1'b0}};
              if (eff_y_s == Y_LAST) begin
                state_r <= FLUSH;
              end else begin
                y_r <= eff_y_s + Y_W'(1);
              end
            end else begin
              x_r <= eff_x_s + X_W'(1);
            end
          end
        end
        FLUSH: begin
          if (x_wrap_s) begin
            x_r         <= {X_W{1'b0}};
            state_r     <= DRAIN;
            drain_cnt_r <= {DW{1'b0}};
          end else begin
            x_r <= eff_x_s + X_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r      <= IDLE;
            y_r          <= {Y_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          x_r     <= {X_W{1'b0}};
          y_r     <= {Y_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase

      // Triple for centre (x, y-1) while rows arrive; (x, V-1) during flush.
      if (issue_s) begin
        issue_x_r <= eff_x_s;
        if (flush_s) begin
          ed_prev_r <= lb_b_rd_s;
          ed_cur_r  <= lb_a_rd_s;
          ed_next_r <= lb_a_rd_s;
          issue_y_r <= eff_y_s;
        end else if (eff_y_s == Y_ONE) begin
          ed_prev_r <= lb_a_rd_s;
          ed_cur_r  <= lb_a_rd_s;
          ed_next_r <= bus.pix_data;
          issue_y_r <= eff_y_s - Y_W'(1);
        end else begin
          ed_prev_r <= lb_b_rd_s;
          ed_cur_r  <= lb_a_rd_s;
          ed_next_r <= bus.pix_data;
          issue_y_r <= eff_y_s - Y_W'(1);
        end
      end
      issue_r <= issue_s;

      // Tags ride alongside the detector; an abort discards everything in flight.
      pipe_x_r[0] <= issue_x_r;
      pipe_y_r[0] <= issue_y_r;
      for (int i = 1; i < EDGE_LAT; i++) begin
        pipe_x_r[i] <= pipe_x_r[i-1];
        pipe_y_r[i] <= pipe_y_r[i-1];
      end
      if (start_s) begin
        pipe_v_r    <= {EDGE_LAT{1'b0}};
        out_valid_r <= 1'b0;
      end else begin
        pipe_v_r[0] <= issue_r;
        for (int i = 1; i < EDGE_LAT; i++) begin
          pipe_v_r[i] <= pipe_v_r[i-1];
        end
        out_valid_r <= pipe_v_r[EDGE_LAT-1];
      end
      if (pipe_v_r[EDGE_LAT-1]) begin
        out_data_r <= bus.edge_in;
        out_x_r    <= pipe_x_r[EDGE_LAT-1];
        out_y_r    <= pipe_y_r[EDGE_LAT-1];
      end
    end
  end

  assign bus.ed_prev    = ed_prev_r;
  assign bus.ed_cur     = ed_cur_r;
  assign bus.ed_next    = ed_next_r;
  assign bus.ed_rst     = ed_rst_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_x      = out_x_r;
  assign bus.out_y      = out_y_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_edge_line_sequencer.sv
// -----------------------------------------------------------------------------
// tb_edge_line_sequencer
// Scoreboard bench for edge_line_sequencer on a 4x3 frame with a stub detector
// that delays ed_cur by three registers. The driver builds each frame image,
// derives every expected triple/result from the image with border clamping
// and the pixel-to-output latency, and queues them with their due cycle; a
// negedge monitor pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_edge_line_sequencer;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int LAT = 3;
  localparam int XW  = 2;
  localparam int YW  = 2;
  localparam int OUT_LAT = 1 + LAT + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_line_sequencer_if #(.X_W(XW), .Y_W(YW)) bus ();

  edge_line_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW), .EDGE_LAT(LAT)
  ) dut (
    .VGA_CLK(clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  // Stub detector: edge_out is ed_cur delayed by three registers.
  logic [7:0] d1 = 8'd0, d2 = 8'd0;
  initial bus.edge_in = 8'd0;
  always @(posedge clk) begin
    d1          <= bus.ed_cur;
    d2          <= d1;
    bus.edge_in <= d2;
  end

  typedef struct {
    int         due;
    int         x;
    int         y;
    logic [7:0] p;
    logic [7:0] c;
    logic [7:0] n;
  } exp_t;

  exp_t out_q[$];
  exp_t ed_q[$];
  int   done_q[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   exp_ovr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the queued expectations each cycle.
  always @(negedge clk) begin
    while (ed_q.size() > 0 && ed_q[0].due == cyc) begin
      me = ed_q.pop_front();
      check($sformatf("ed_prev(%0d,%0d)", me.x, me.y), bus.ed_prev, me.p);
      check($sformatf("ed_cur(%0d,%0d)",  me.x, me.y), bus.ed_cur,  me.c);
      check($sformatf("ed_next(%0d,%0d)", me.x, me.y), bus.ed_next, me.n);
    end
    while (out_q.size() > 0 && out_q[0].due < cyc) begin
      me = out_q.pop_front();
      n_chk++; n_fail++;
      $display("FAIL out_missing: result (%0d,%0d) due cycle %0d never seen, now %0d", me.x, me.y, me.due, cyc);
    end
    if (bus.out_valid === 1'b1) begin
      if (out_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out_unexpected: out_valid with x=%0d y=%0d at cycle %0d, none expected", bus.out_x, bus.out_y, cyc);
      end else begin
        me = out_q.pop_front();
        check("out_cycle", cyc, me.due);
        check("out_x", bus.out_x, me.x);
        check("out_y", bus.out_y, me.y);
        check("out_data", bus.out_data, me.c);
      end
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL frame_done_missing: due cycle %0d, now %0d", done_q.pop_front(), cyc);
    end
    if (bus.frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL frame_done_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        check("frame_done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic start_checks(input int s);
    if (cyc == s + 1) begin
      check("ed_rst_pulse", bus.ed_rst, 1);
      check("busy_after_start", bus.busy, 1);
      check("overrun_after_start", bus.overrun, exp_ovr);
    end else if (cyc == s + 2) begin
      check("ed_rst_fall", bus.ed_rst, 0);
    end
  endtask

  // gap_mode: 0 continuous, 1 toggling, 2 random gaps.
  task automatic send_frame(input int gap_mode, input bit det, input bit do_abort,
                            input bit poke, input bit skip_start, input int s_in,
                            output int a_out);
    logic [7:0] img [V][H];
    int   s, t, lst, tries;
    bit   v, coincide, tog;
    exp_t e;
    a_out = -1;
    t = 0;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = det ? 8'(10 * r + c) : 8'($urandom_range(0, 255));
    coincide = 1'b0;
    if (skip_start) begin
      s = s_in;
      exp_ovr = 1'b1;
    end else begin
      coincide = det ? 1'b0 : ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      bus.enable      = 1'b1;
      bus.frame_start = 1'b1;
      bus.pix_valid   = coincide;
      bus.pix_data    = img[0][0];
      s = cyc;
      exp_ovr = 1'b0;
    end
    tog = 1'b0;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        if (!(r == 0 && c == 0 && coincide)) begin
          if (do_abort && r == 2 && c == 1) begin
            @(posedge clk); #1;
            start_checks(s);
            bus.frame_start = 1'b1;
            bus.pix_valid   = 1'b0;
            a_out = cyc;
            while (out_q.size() > 0 && out_q[$].due > cyc) void'(out_q.pop_back());
            exp_ovr = 1'b1;
            return;
          end
          tries = 0;
          do begin
            @(posedge clk); #1;
            start_checks(s);
            bus.frame_start = 1'b0;
            case (gap_mode)
              0:       v = 1'b1;
              1:       begin v = tog; tog = !tog; end
              default: v = ($urandom_range(0, 2) != 0) || (tries >= 3);
            endcase
            tries++;
            bus.pix_valid = v;
            bus.pix_data  = v ? img[r][c] : 8'($urandom_range(0, 255));
          end while (!v);
          t = cyc;
          if (r >= 1) begin
            e.x = c; e.y = r - 1;
            e.p = img[(r >= 2) ? r - 2 : 0][c];
            e.c = img[r-1][c];
            e.n = img[r][c];
            e.due = t + 1;       ed_q.push_back(e);
            e.due = t + OUT_LAT; out_q.push_back(e);
          end
        end
      end
    end
    lst = t;
    for (int k = 0; k < H; k++) begin
      e.x = k; e.y = V - 1;
      e.p = img[V-2][k];
      e.c = img[V-1][k];
      e.n = img[V-1][k];
      e.due = lst + 1 + k + 1;       ed_q.push_back(e);
      e.due = lst + 1 + k + OUT_LAT; out_q.push_back(e);
    end
    done_q.push_back(lst + H + OUT_LAT + 1);
    for (int k = 0; k < H; k++) begin
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      bus.pix_valid   = poke && (k == 0 || $urandom_range(0, 1) == 1);
      bus.pix_data    = 8'($urandom_range(0, 255));
    end
    if (poke) exp_ovr = 1'b1;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    while (cyc < lst + H + OUT_LAT + 2) begin
      @(posedge clk); #1;
    end
    check("busy_after_frame", bus.busy, 0);
    check("overrun_after_frame", bus.overrun, exp_ovr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2;
    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'd0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ed_rst", bus.ed_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_ed_cur", bus.ed_cur, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ed_rst", bus.ed_rst, 0);
    check("post_rst_busy", bus.busy, 0);

    // frame_start without enable must be ignored
    bus.enable      = 1'b0;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    check("disabled_start_busy", bus.busy, 0);
    check("disabled_start_ed_rst", bus.ed_rst, 0);

    send_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, a);   // 10*y+x, continuous
    send_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, 0, a);   // 10*y+x, toggling valid
    repeat (3) send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, a);
    send_frame(2, 1'b0, 1'b1, 1'b0, 1'b0, 0, a);   // aborted in row 2
    send_frame(2, 1'b0, 1'b0, 1'b0, 1'b1, a, a2);  // frame started by the abort
    send_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 0, a);   // pixels poked during flush
    send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, a);   // clean start clears overrun

    repeat (10) @(posedge clk);
    #1;
    check("out_queue_drained", out_q.size(), 0);
    check("ed_queue_drained", ed_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_line_sequencer.md
Name: edge_line_sequencer

Overview:
- Streaming controller that sequences the 3-tap vertical edge detector.
- Buffers two video lines and presents each centre pixel together with its above/below neighbours to the detector, one set per clock.
- Handles top/bottom border replication, compensates the detector's pipeline latency, and tags each result with x/y.
- Sits between the camera/pixel source and the VGA frame writer.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- X_W, 10, width of x counter/line-buffer address.
- Y_W, 9, width of y counter.
- EDGE_LAT, 3, detector latency in cycles from inputs to edge_out.

Ports:
- VGA_CLK  in  1  pixel clock, all logic rising edge.
- RST_N  in  1  synchronous active-low reset.
- enable  in  1  arms the sequencer for the next frame_start.
- frame_start  in  1  one-cycle start-of-frame strobe; may coincide with pixel (0,0).
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  8  incoming luma pixel, raster order.
- ed_prev  out  8  pixel above centre (to detector prev_pixel).
- ed_cur  out  8  centre pixel (to detector pixel_in).
- ed_next  out  8  pixel below centre (to detector next_pixel).
- ed_rst  out  1  active-high reset to detector.
- edge_in  in  8  detector edge_out.
- out_valid  out  1  out_data/out_x/out_y valid.
- out_data  out  8  edge result.
- out_x  out  X_W  column of result.
- out_y  out  Y_W  row of result.
- busy  out  1  high in FILL/RUN/FLUSH/DRAIN.
- frame_done  out  1  one-cycle pulse after the last result of a frame.
- overrun  out  1  sticky error flag, cleared by frame_start or reset.

Behaviour:
- Reset (RST_N=0 at clock edge): state IDLE, counters 0, all outputs 0 except ed_rst=1. ed_rst falls the first cycle after RST_N=1.
- Line buffers: LB_A holds row y-1, LB_B holds row y-2, each H_ACTIVE deep. An accepted pixel at column x reads both at address x, then shifts: LB_B[x]<=LB_A[x], LB_A[x]<=pix_data.
- States:
  - IDLE: pix_valid ignored. frame_start with enable=1 -> FILL, x=y=0, overrun cleared, ed_rst pulsed high 1 cycle.
  - FILL (row 0 arriving): store only, no detector issue. When x wraps -> RUN, y=1.
  - RUN: each accepted pixel issues one set, centre = (x, y-1).
    - y==1 (top border): ed_prev=ed_cur=LB_A[x].
    - Otherwise: ed_prev=LB_B[x], ed_cur=LB_A[x], ed_next=pix_data.
    - On the last pixel of row V_ACTIVE-1 -> FLUSH.
  - FLUSH: self-timed, one issue per cycle for x=0..H_ACTIVE-1, centre row V_ACTIVE-1. ed_prev=LB_B[x], ed_cur=ed_next=LB_A[x] (bottom replication). pix_valid during FLUSH: pixel dropped, overrun<=1. After x wraps -> DRAIN.
  - DRAIN: waits EDGE_LAT cycles. After the final out_valid, frame_done pulses 1 cycle -> IDLE.
- Issue timing: ed_* registered, valid the cycle after acceptance. Internal issue strobe, x and y delayed by an EDGE_LAT-deep shift register. out_valid/out_x/out_y align with edge_in; out_data=edge_in registered. Total pixel-in to out_valid latency = 1+EDGE_LAT+1 cycles.
- x wraps at H_ACTIVE-1 to 0; y increments on wrap. No counter exceeds H_ACTIVE-1 / V_ACTIVE-1.
- frame_start in FILL/RUN/FLUSH/DRAIN: abort. Pipeline shift register cleared (no out_valid for the aborted frame), frame_done not pulsed, ed_rst pulsed, overrun<=1, restart in FILL with x=y=0. If pix_valid is also high that cycle, that pixel is (0,0) of the new frame.
- frame_start with enable=0 in IDLE: ignored.
- Reset mid-frame: immediate return to IDLE. Line-buffer contents undefined but never emitted.

Test Plan (H_ACTIVE=4, V_ACTIVE=3, EDGE_LAT=3, stub detector = registered 3-cycle delay of ed_cur):
- Reset release: RST_N low 2 cycles -> all outputs 0, ed_rst=1; first cycle after RST_N high ed_rst=0, busy=0.
- Full frame with pix_data=10*y+x, continuous pix_valid -> 12 out_valid pulses in raster order. Row 0 triples (0,0,10); row 2 triples (10,20,20). out_data equals centre, frame_done 1 cycle after last result.
- Latency: first row-1 pixel accepted at cycle t -> ed_* valid at t+1, out_valid at t+1+EDGE_LAT+1 with out_x=0, out_y=0.
- Gapped input (pix_valid toggling 1/0) -> same 12 results and values; out_valid only on issued sets.
- frame_start during RUN row 2 -> overrun=1, no further outputs from old frame, no frame_done, ed_rst pulse, new frame completes correctly.
- pix_valid during FLUSH -> pixel dropped, overrun=1, remaining flush results unaffected.
